// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding memory request at a
// time and hands (pc, inst) to decode. Define IF_PREFETCH_EN to allow a request in the drain cycle.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  input  logic        id_ready_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        kill;

  logic        drain;
  logic        can_take;
  logic [31:0] jump_target;
  logic        unused_jump_bits;

  assign drain       = inst_valid_o && id_ready_i;
  assign jump_target = {jump_addr_i[31:2], 2'b00};
  assign unused_jump_bits = ^jump_addr_i[1:0];

`ifdef IF_PREFETCH_EN
  assign can_take = !inst_valid_o || drain;
`else
  assign can_take = !inst_valid_o;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      kill         <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= RESET_PC;
      inst_valid_o <= 1'b0;
      // NOTE: the payload registers are reset too because decode-side tooling
      // expects pc_o/inst_o to read zero out of reset, not just a cleared valid.
      pc_o         <= 32'h0;
      inst_o       <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees the
      // pre-edge values and the later clear of inst_valid_o on a jump wins cleanly.
      if (drain) inst_valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (jump_i) begin
            // The register is being flushed, so the target can be requested at once.
            fetch_pc   <= jump_target;
            mem_addr_o <= jump_target;
            mem_req_o  <= 1'b1;
            state      <= REQ;
          end else if (can_take) begin
            mem_addr_o <= fetch_pc;
            mem_req_o  <= 1'b1;
            state      <= REQ;
          end
        end

        REQ: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            kill      <= 1'b0;
            state     <= IDLE;
            if (jump_i) begin
              fetch_pc <= jump_target;
            end else if (!kill) begin
              inst_valid_o <= 1'b1;
              pc_o         <= fetch_pc;
              inst_o       <= mem_rdata_i;
              fetch_pc     <= fetch_pc + 32'd4;
            end
          end else if (jump_i) begin
            // The old request stays on the bus; its data is dropped when it returns.
            kill     <= 1'b1;
            fetch_pc <= jump_target;
          end
        end

        default: state <= IDLE;
      endcase

      if (jump_i) inst_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a transaction-level model compared every cycle,
// plus directed scenarios with hand-computed pc sequences and timing.
module tb_if_fetch;

`ifdef IF_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
  localparam int GAP      = 2;
`else
  localparam bit PREFETCH = 1'b0;
  localparam int GAP      = 3;
`endif
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        id_ready = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = 32'h0;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .inst_valid_o(inst_valid), .pc_o(pc), .inst_o(inst),
    .id_ready_i(id_ready), .jump_i(jump), .jump_addr_i(jump_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  int cyc = 0;

  int          acc_cyc[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_inst[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Transaction-level model: one outstanding fetch, a stale flag for wrong-path
  // fetches, the next PC to fetch, and the decode-facing holding register.
  logic        m_busy, m_stale, m_valid;
  logic [31:0] m_addr, m_next, m_pc, m_inst;

  always @(posedge clk) begin
    logic [31:0] tgt;
    logic room, done, good;
    cyc++;
    if (rst) begin
      m_busy = 0; m_stale = 0; m_valid = 0;
      m_addr = RESET_PC; m_next = RESET_PC; m_pc = 0; m_inst = 0;
    end else begin
      if (inst_valid && id_ready) begin
        acc_cyc.push_back(cyc);
        acc_pc.push_back(pc);
        acc_inst.push_back(inst);
      end
      tgt  = jump_addr & ~32'h3;
      room = !m_valid || (PREFETCH && id_ready);
      done = m_busy && mem_ack;
      good = done && !m_stale && !jump;
      if (jump) m_valid = 0;
      else if (good) begin m_valid = 1; m_pc = m_addr; m_inst = mem_rdata; end
      else if (m_valid && id_ready) m_valid = 0;
      if (m_busy) begin
        if (jump) m_next = tgt;
        else if (good) m_next = m_addr + 32'd4;
        if (done) begin m_busy = 0; m_stale = 0; end
        else if (jump) m_stale = 1;
      end else if (jump) begin
        m_next = tgt; m_addr = tgt; m_busy = 1;
      end else if (room) begin
        m_addr = m_next; m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_req",   {31'h0, mem_req},    {31'h0, m_busy});
      check("cmp_addr",  mem_addr,            m_addr);
      check("cmp_valid", {31'h0, inst_valid}, {31'h0, m_valid});
      check("cmp_pc",    pc,                  m_pc);
      check("cmp_inst",  inst,                m_inst);
    end
  end

  // Called just after a falling edge: drive inputs, advance one full cycle.
  task automatic tick(input logic ack, input logic ready, input logic jmp, input logic [31:0] ja);
    mem_ack   = ack;
    mem_rdata = word(mem_addr);
    id_ready  = ready;
    jump      = jmp;
    jump_addr = ja;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    cmp_en = 1'b1;
    acc_cyc.delete(); acc_pc.delete(); acc_inst.delete();
    rst = 1'b0;
  endtask

  task automatic run_until_acc(input int n, input string name);
    for (int i = 0; i < 100 && acc_pc.size() < n; i++) tick(mem_req, 1, 0, 0);
    check(name, acc_pc.size(), n);
  endtask

  task automatic find_req(input logic [31:0] a, input string name);
    for (int i = 0; i < 50 && !(mem_req && mem_addr == a); i++) tick(mem_req, 1, 0, 0);
    check(name, {31'h0, mem_req}, 32'h1);
  endtask

  initial begin
    @(negedge clk);

    // Reset values, first request, then a sequential stream with 1-cycle memory.
    rst = 1'b1;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("rst_req",   {31'h0, mem_req}, 32'h0);
    check("rst_addr",  mem_addr, RESET_PC);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_pc",    pc, 32'h0);
    check("rst_inst",  inst, 32'h0);
    do_reset();
    tick(0, 1, 0, 0);
    check("first_req",  {31'h0, mem_req}, 32'h1);
    check("first_addr", mem_addr, RESET_PC);
    run_until_acc(3, "seq_count");
    if (acc_pc.size() >= 3) begin
      check("seq_pc0", acc_pc[0], 32'h0);
      check("seq_pc1", acc_pc[1], 32'h4);
      check("seq_pc2", acc_pc[2], 32'h8);
      check("seq_inst1", acc_inst[1], 32'h1357_9BDB);
      check("seq_gap01", acc_cyc[1] - acc_cyc[0], GAP);
      check("seq_gap12", acc_cyc[2] - acc_cyc[1], GAP);
    end

    // Decode stall for five cycles with a valid instruction held.
    do_reset();
    for (int i = 0; i < 20 && !inst_valid; i++) tick(mem_req, 0, 0, 0);
    check("stall_valid", {31'h0, inst_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick(mem_req, 0, 0, 0);
      check("stall_pc",   pc, 32'h0);
      check("stall_inst", inst, 32'h1357_9BDF);
      check("stall_req",  {31'h0, mem_req}, 32'h0);
    end
    run_until_acc(2, "stall_count");
    if (acc_pc.size() >= 2) check("stall_next", acc_pc[1], 32'h4);

    // Jump while the request to 0x8 is pending; that request is acked 3 cycles later.
    do_reset();
    find_req(32'h8, "kill_find");
    tick(0, 1, 1, 32'h100);
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 0, 0);
      check("kill_hold_req",  {31'h0, mem_req}, 32'h1);
      check("kill_hold_addr", mem_addr, 32'h8);
      check("kill_valid",     {31'h0, inst_valid}, 32'h0);
    end
    tick(1, 1, 0, 0);
    check("kill_drop", {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < 10 && !mem_req; i++) tick(0, 1, 0, 0);
    check("kill_next_addr", mem_addr, 32'h100);
    run_until_acc(3, "kill_count");
    if (acc_pc.size() >= 3) check("kill_target", acc_pc[2], 32'h100);

    // Jump to an unaligned target in the same cycle as the ack and decode accept.
    do_reset();
    find_req(32'h4, "jack_find");
    tick(1, 1, 1, 32'h203);
    check("jack_valid", {31'h0, inst_valid}, 32'h0);
    tick(0, 1, 0, 0);
    check("jack_req",  {31'h0, mem_req}, 32'h1);
    check("jack_addr", mem_addr, 32'h200);
    run_until_acc(2, "jack_count");
    if (acc_pc.size() >= 2) check("jack_pc", acc_pc[1], 32'h200);

    // Jump from IDLE to the last word, then wrap to 0.
    do_reset();
    tick(0, 1, 1, 32'hFFFF_FFFC);
    check("wrap_req",  {31'h0, mem_req}, 32'h1);
    check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    run_until_acc(2, "wrap_count");
    if (acc_pc.size() >= 2) begin
      check("wrap_pc0", acc_pc[0], 32'hFFFF_FFFC);
      check("wrap_pc1", acc_pc[1], 32'h0);
    end

    // Reset while a killed request is outstanding.
    do_reset();
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 32'h40);
    rst = 1'b1;
    tick(0, 1, 0, 0);
    check("rkill_req",   {31'h0, mem_req}, 32'h0);
    check("rkill_valid", {31'h0, inst_valid}, 32'h0);
    rst = 1'b0;
    tick(0, 1, 0, 0);
    check("rkill_first_req",  {31'h0, mem_req}, 32'h1);
    check("rkill_first_addr", mem_addr, RESET_PC);
    run_until_acc(1, "rkill_count");
    if (acc_pc.size() >= 1) check("rkill_pc", acc_pc[0], RESET_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
